board_clk_led_ctrl: RTL and testbench

Board-level I/O controller between the FPGA pins and the cpu core.
- Derives the slow CPU clock SLOW_CLK from CLK, with three modes: free-run, button single-step, and hold.
- Debounces the step button.
- Drives WIDTH LED channels with per-channel PWM brightness, so dimming is no longer hard-coded per bit.

---
 rtl/board_clk_led_ctrl.sv | 162 ++++++++++++++++
 tb/tb_board_clk_led_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_clk_led_ctrl.sv
// Board I/O controller: slow CPU clock generator (run / single-step / hold),
// step-button debouncer and per-channel PWM LED driver.
module board_clk_led_ctrl #(
  parameter int DIV        = 10_000_000,
  parameter int PWM_PERIOD = 100,
  parameter int LVL_W      = 7,
  parameter int DEBOUNCE   = 1_000_000,
  parameter int WIDTH      = 8,
  parameter bit SHOW_CLK   = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   BUTTON,
  input  logic [1:0]             MODE,
  input  logic [WIDTH-1:0]       DATA,
  input  logic [WIDTH*LVL_W-1:0] BRIGHT,
  output logic                   SLOW_CLK,
  output logic                   TICK,
  output logic                   BTN_PRESS,
  output logic [WIDTH-1:0]       OUTPUT
);

  localparam int DIV_W = $clog2(DIV);
  localparam int DEB_W = $clog2(DEBOUNCE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [LVL_W-1:0] PWM_LAST = LVL_W'(PWM_PERIOD - 1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_STEP_IDLE  = 2'd1,
    S_STEP_PULSE = 2'd2,
    S_HOLD       = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Step button: two-flop synchroniser followed by a stability counter.
  // ---------------------------------------------------------------------------
  logic             sync1;
  logic             sync2;
  logic             btn_level;
  logic [DEB_W-1:0] deb_cnt;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_level <= 1'b0;
      deb_cnt   <= '0;
      BTN_PRESS <= 1'b0;
    end else begin
      sync1     <= BUTTON;
      sync2     <= sync1;
      BTN_PRESS <= 1'b0;
      if (sync2 == btn_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        btn_level <= sync2;
        BTN_PRESS <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slow clock FSM. A step pulse reuses the upper half of the divider count,
  // so SLOW_CLK always equals (div_cnt >= DIV/2).
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic             step_mode;
  logic             hold_mode;

  assign cnt_inc   = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign step_mode = (MODE == 2'b01);
  assign hold_mode = (MODE == 2'b10);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_RUN;
      div_cnt  <= '0;
      SLOW_CLK <= 1'b0;
      TICK     <= 1'b0;
    end else begin
      TICK <= 1'b0;
      if (hold_mode) begin
        state <= S_HOLD;
      end else begin
        unique case (state)
          // Leaving for step mode waits out a high phase instead of cutting it.
          S_RUN, S_HOLD: begin
            if (step_mode && !SLOW_CLK) begin
              state   <= S_STEP_IDLE;
              div_cnt <= '0;
            end else begin
              div_cnt  <= cnt_inc;
              SLOW_CLK <= (cnt_inc >= DIV_HALF);
              TICK     <= (cnt_inc == DIV_HALF);
              state    <= (step_mode && cnt_inc == '0) ? S_STEP_IDLE : S_RUN;
            end
          end
          S_STEP_IDLE: begin
            if (!step_mode) begin
              state   <= S_RUN;
              div_cnt <= '0;
            end else if (BTN_PRESS) begin
              state    <= S_STEP_PULSE;
              div_cnt  <= DIV_HALF;
              SLOW_CLK <= 1'b1;
              TICK     <= 1'b1;
            end
          end
          S_STEP_PULSE: begin
            div_cnt  <= cnt_inc;
            SLOW_CLK <= (cnt_inc >= DIV_HALF);
            if (!step_mode) begin
              state <= S_RUN;
            end else if (cnt_inc == '0) begin
              state <= S_STEP_IDLE;
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM LED driver, free running regardless of MODE.
  // ---------------------------------------------------------------------------
  logic [LVL_W-1:0] pwm_cnt;
  logic [WIDTH-1:0] led_src;

  // NOTE: every always_comb output gets a full default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    led_src = DATA;
    if (SHOW_CLK) begin
      led_src[WIDTH-1] = SLOW_CLK;
    end
  end

  // A level at or above PWM_PERIOD always exceeds pwm_cnt, so it saturates on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pwm_cnt <= '0;
      OUTPUT  <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        OUTPUT[i] <= led_src[i] && (pwm_cnt < BRIGHT[i*LVL_W +: LVL_W]);
      end
    end
  end

endmodule

// File: tb/tb_board_clk_led_ctrl.sv
// Self-checking bench for board_clk_led_ctrl: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural model.
module tb_board_clk_led_ctrl;

  localparam int DIV        = 10;
  localparam int PWM_PERIOD = 10;
  localparam int LVL_W      = 7;
  localparam int DEBOUNCE   = 4;
  localparam int WIDTH      = 8;
  localparam int HALF       = DIV / 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   button;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       data;
  logic [WIDTH*LVL_W-1:0] bright;
  logic                   slow_clk;
  logic                   tick;
  logic                   btn_press;
  logic [WIDTH-1:0]       leds;

  board_clk_led_ctrl #(
    .DIV        (DIV),
    .PWM_PERIOD (PWM_PERIOD),
    .LVL_W      (LVL_W),
    .DEBOUNCE   (DEBOUNCE),
    .WIDTH      (WIDTH),
    .SHOW_CLK   (1'b1)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .BUTTON    (button),
    .MODE      (mode),
    .DATA      (data),
    .BRIGHT    (bright),
    .SLOW_CLK  (slow_clk),
    .TICK      (tick),
    .BTN_PRESS (btn_press),
    .OUTPUT    (leds)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: position inside a DIV-long slow period plus what the
  // clock is currently doing (free running, awaiting a press, pulsing).
  localparam int C_FREE    = 0;
  localparam int C_AWAIT   = 1;
  localparam int C_PULSING = 2;

  int               pos = 0;
  int               ctx = C_FREE;
  int               frame = 0;
  int               run_len = 0;
  bit               accepted = 1'b0;
  bit               seen_1 = 1'b0;
  bit               seen_2 = 1'b0;
  bit               exp_slow = 1'b0;
  bit               exp_tick = 1'b0;
  bit               exp_press = 1'b0;
  logic [WIDTH-1:0] exp_leds = '0;

  int               cyc = 0;
  int               n_press = 0;
  int               n_tick = 0;
  int               n_high = 0;
  int               n_led_chg = 0;
  int               first_press = -1;
  int               ch_on [WIDTH];
  logic [WIDTH-1:0] prev_leds = '0;
  int               c0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit old_slow;
    bit old_press;
    bit lvl;
    bit src;
    int phase;
    old_slow  = exp_slow;
    old_press = exp_press;
    if (rst) begin
      pos = 0; ctx = C_FREE; frame = 0; run_len = 0;
      accepted = 1'b0; seen_1 = 1'b0; seen_2 = 1'b0;
      exp_slow = 1'b0; exp_tick = 1'b0; exp_press = 1'b0; exp_leds = '0;
      return;
    end
    phase = frame % PWM_PERIOD;
    for (int i = 0; i < WIDTH; i++) begin
      src = (i == WIDTH - 1) ? old_slow : data[i];
      exp_leds[i] = src && (phase < int'(bright[i*LVL_W +: LVL_W]));
    end
    frame++;
    // The debouncer sees the button as it was two edges ago.
    lvl = seen_2;
    seen_2 = seen_1;
    seen_1 = button;
    exp_press = 1'b0;
    if (lvl != accepted) begin
      run_len++;
      if (run_len == DEBOUNCE) begin
        accepted  = lvl;
        run_len   = 0;
        exp_press = lvl;
      end
    end else begin
      run_len = 0;
    end
    exp_tick = 1'b0;
    if (mode == 2'b10) begin
      ctx = C_FREE;
    end else if (mode == 2'b01) begin
      if (ctx == C_AWAIT) begin
        if (old_press) begin
          ctx = C_PULSING; pos = HALF; exp_tick = 1'b1;
        end
      end else if (ctx == C_FREE && pos < HALF) begin
        ctx = C_AWAIT; pos = 0;
      end else begin
        pos = (pos + 1) % DIV;
        if (pos == 0) ctx = C_AWAIT;
      end
    end else begin
      if (ctx == C_AWAIT) begin
        pos = 0;
      end else begin
        pos = (pos + 1) % DIV;
        exp_tick = (pos == HALF);
      end
      ctx = C_FREE;
    end
    exp_slow = (pos >= HALF);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_edge();
      check("slow_clk", slow_clk, exp_slow);
      check("tick", tick, exp_tick);
      check("btn_press", btn_press, exp_press);
      check("leds", leds, exp_leds);
      cyc++;
      if (btn_press) begin
        n_press++;
        if (first_press < 0) first_press = cyc;
      end
      if (tick) n_tick++;
      if (slow_clk) n_high++;
      if (leds != prev_leds) n_led_chg++;
      prev_leds = leds;
      for (int i = 0; i < WIDTH; i++) if (leds[i]) ch_on[i]++;
    end
  endtask

  task automatic clear_obs();
    n_press = 0; n_tick = 0; n_high = 0; n_led_chg = 0; first_press = -1;
    for (int i = 0; i < WIDTH; i++) ch_on[i] = 0;
  endtask

  task automatic set_level(input int ch, input int v);
    bright[ch*LVL_W +: LVL_W] = LVL_W'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; button = 1'b0; mode = 2'b00;
    data = WIDTH'($urandom);
    for (int i = 0; i < WIDTH; i++) set_level(i, $urandom_range(0, 127));

    // Reset: every output low regardless of inputs.
    step(3);
    check("reset_leds", leds, 0);
    check("reset_slow", slow_clk, 0);

    // Free run: period 10, high for counts 5..9, one tick per period.
    rst = 1'b0;
    clear_obs();
    step(30);
    check("run_ticks", n_tick, 3);
    check("run_high_cycles", n_high, 15);

    // Enter step mode at count 7: the high phase finishes before idling.
    for (int k = 0; k < DIV && pos != 7; k++) step(1);
    mode = 2'b01;
    step(2);
    check("step_no_truncate", slow_clk, 1);
    step(1);
    check("step_idle_low", slow_clk, 0);
    step(3);

    // Clean press: BTN_PRESS 6 cycles after the rise, then one 5-cycle pulse.
    c0 = cyc;
    clear_obs();
    button = 1'b1;
    step(10);
    button = 1'b0;
    step(10);
    check("press_latency", first_press - c0, 6);
    check("press_count", n_press, 1);
    check("pulse_len", n_high, 5);
    check("pulse_ticks", n_tick, 1);

    // Bouncing button: no press, no tick.
    clear_obs();
    for (int k = 0; k < 10; k++) begin
      button = ~button;
      step(2);
    end
    step(6);
    check("bounce_press", n_press, 0);
    check("bounce_tick", n_tick, 0);

    // A press taken in RUN is not queued for step mode.
    mode = 2'b00;
    button = 1'b1;
    step(8);
    mode = 2'b01;
    clear_obs();
    step(15);
    check("run_press_not_queued", n_tick, 0);
    button = 1'b0;
    step(8);

    // A press taken in HOLD is not queued either.
    mode = 2'b10;
    button = 1'b1;
    step(8);
    mode = 2'b01;
    clear_obs();
    step(15);
    check("hold_press_not_queued", n_tick, 0);
    button = 1'b0;
    step(8);

    // Hold at count 3: frozen for 50 cycles while PWM keeps running.
    data = 8'h02;
    set_level(1, 3);
    mode = 2'b00;
    for (int k = 0; k < DIV + 1 && pos != 3; k++) step(1);
    mode = 2'b10;
    clear_obs();
    step(50);
    check("hold_ticks", n_tick, 0);
    check("hold_high", n_high, 0);
    check("hold_pwm_alive", n_led_chg > 0, 1);
    mode = 2'b00;
    step(1);
    check("resume_tick_early", tick, 0);
    step(1);
    check("resume_tick", tick, 1);

    // Brightness levels: 0 off, 3 of 10, >= period always on.
    data = 8'h0F;
    set_level(0, 0);  set_level(1, 3);  set_level(2, 10); set_level(3, 127);
    set_level(4, 5);  set_level(5, 2);  set_level(6, 9);  set_level(7, 6);
    step(1);
    clear_obs();
    step(10);
    check("ch0_off", ch_on[0], 0);
    check("ch1_duty", ch_on[1], 3);
    check("ch2_full", ch_on[2], 10);
    check("ch3_saturate", ch_on[3], 10);
    check("ch4_data_off", ch_on[4], 0);
    data[2] = 1'b0;
    step(1);
    check("data_latency", leds[2], 0);
    set_level(0, 127);
    step(1);
    check("bright_latency", leds[0], 1);

    // Reset in the middle of a step pulse with the button held.
    mode = 2'b01;
    for (int k = 0; k < 12 && ctx != C_AWAIT; k++) step(1);
    button = 1'b1;
    for (int k = 0; k < 12 && !slow_clk; k++) step(1);
    check("pulse_started", slow_clk, 1);
    step(2);
    rst = 1'b1;
    step(1);
    check("rst_slow", slow_clk, 0);
    check("rst_tick", tick, 0);
    check("rst_leds", leds, 0);
    step(1);
    c0 = cyc;
    rst = 1'b0;
    clear_obs();
    step(15);
    check("post_rst_press_latency", first_press - c0, 6);
    check("post_rst_press_count", n_press, 1);
    check("post_rst_ticks", n_tick, 1);
    button = 1'b0;
    step(8);

    // Random mix of modes, button activity, display inputs and resets.
    mode = 2'b00;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) button = ~button;
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        data = WIDTH'($urandom);
        set_level($urandom_range(0, WIDTH - 1), $urandom_range(0, 127));
      end
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
